// File: rtl/class_decide_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | class_decide_pkg                                                     |
// | Shared state type, class encodings and limits for class_decide.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package class_decide_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WINDOW = 3'd1,
    ST_SETTLE = 3'd2,
    ST_DECIDE = 3'd3,
    ST_OUT    = 3'd4
  } state_t;

  localparam logic [1:0] CLS_NONE = 2'b00;
  localparam logic [1:0] CLS_N1   = 2'b01;
  localparam logic [1:0] CLS_N2   = 2'b10;
  localparam logic [1:0] CLS_TIE  = 2'b11;

  localparam int WINDOW_LEN_MAX = 14;
  localparam int POT_W          = 3;

  function automatic logic [1:0] classify(input logic [POT_W-1:0] c1,
                                          input logic [POT_W-1:0] c2);
    logic [1:0] r;
    if (c1 > c2)               r = CLS_N1;
    else if (c2 > c1)          r = CLS_N2;
    else if (c1 == '0)         r = CLS_NONE;
    else                       r = CLS_TIE;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/class_decide_cmp.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | class_cmp                                                            |
// | Modular per-window deltas and winner classification (combinational). |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module class_cmp
  import class_decide_pkg::*;
(
  input  logic [POT_W-1:0] pot1_i,
  input  logic [POT_W-1:0] pot2_i,
  input  logic [POT_W-1:0] base1_i,
  input  logic [POT_W-1:0] base2_i,
  output logic [POT_W-1:0] delta1_o,
  output logic [POT_W-1:0] delta2_o,
  output logic [1:0]       class_id_o
);

  // Window length bounds edges to 7, so the wrapped difference is exact.
  always_comb begin
    delta1_o   = pot1_i - base1_i;
    delta2_o   = pot2_i - base2_i;
    class_id_o = classify(delta1_o, delta2_o);
  end

endmodule
`default_nettype wire

// File: rtl/class_decide.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | class_decide                                                         |
// | Gates the output-neuron counters for one window and picks a winner.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module class_decide
  import class_decide_pkg::*;
#(
  parameter int WINDOW_LEN = 14,
  parameter int SETTLE_CYC = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [POT_W-1:0] potential1_s,
  input  logic [POT_W-1:0] potential2_s,
  output logic             en_s,
  output logic             busy,
  output logic             class_valid,
  input  logic             class_ready,
  output logic [1:0]       class_id,
  output logic [POT_W-1:0] count1,
  output logic [POT_W-1:0] count2
);

  localparam int WIN_W = $clog2(WINDOW_LEN_MAX);
  localparam int SET_W = $clog2(SETTLE_CYC);
  localparam int CNT_W = (SET_W > WIN_W) ? SET_W : WIN_W;

  localparam logic [CNT_W-1:0] WIN_LOAD = CNT_W'(WINDOW_LEN - 1);
  localparam logic [CNT_W-1:0] SET_LOAD = CNT_W'(SETTLE_CYC - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [POT_W-1:0]  base1_q, base1_d;
  logic [POT_W-1:0]  base2_q, base2_d;
  logic [POT_W-1:0]  count1_q, count2_q;
  logic [1:0]        class_id_q;
  logic              en_s_q, en_s_d;
  logic              load_result;

  logic [POT_W-1:0]  delta1, delta2;
  logic [1:0]        cmp_id;

  class_cmp u_cmp (
    .pot1_i     (potential1_s),
    .pot2_i     (potential2_s),
    .base1_i    (base1_q),
    .base2_i    (base2_q),
    .delta1_o   (delta1),
    .delta2_o   (delta2),
    .class_id_o (cmp_id)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    base1_d     = base1_q;
    base2_d     = base2_q;
    en_s_d      = 1'b0;
    load_result = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          base1_d = potential1_s;
          base2_d = potential2_s;
          cnt_d   = WIN_LOAD;
          en_s_d  = 1'b1;
          state_d = ST_WINDOW;
        end
      end
      ST_WINDOW: begin
        if (cnt_q == '0) begin
          cnt_d   = SET_LOAD;
          state_d = ST_SETTLE;
        end else begin
          cnt_d  = cnt_q - CNT_W'(1);
          en_s_d = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = ST_DECIDE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DECIDE: begin
        load_result = 1'b1;
        state_d     = ST_OUT;
      end
      ST_OUT: begin
        if (class_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Cancel wins over every other request; results from earlier runs stay visible.
    if (abort) begin
      state_d     = ST_IDLE;
      cnt_d       = '0;
      en_s_d      = 1'b0;
      load_result = 1'b0;
      base1_d     = base1_q;
      base2_d     = base2_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      base1_q    <= '0;
      base2_q    <= '0;
      en_s_q     <= 1'b0;
      count1_q   <= '0;
      count2_q   <= '0;
      class_id_q <= CLS_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      base1_q <= base1_d;
      base2_q <= base2_d;
      en_s_q  <= en_s_d;
      if (load_result) begin
        count1_q   <= delta1;
        count2_q   <= delta2;
        class_id_q <= cmp_id;
      end
    end
  end

  assign en_s        = en_s_q;
  assign busy        = (state_q != ST_IDLE);
  assign class_valid = (state_q == ST_OUT);
  assign class_id    = class_id_q;
  assign count1      = count1_q;
  assign count2      = count2_q;

endmodule
`default_nettype wire

// File: tb/tb_class_decide.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_class_decide                                                      |
// | Directed and random classification runs against a window-edge model. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_class_decide;
  import class_decide_pkg::*;

  localparam int WL = 14;
  localparam int SC = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       class_ready = 1'b0;
  logic [2:0] pot1 = 3'd0;
  logic [2:0] pot2 = 3'd0;
  logic       en_s, busy, class_valid;
  logic [1:0] class_id;
  logic [2:0] count1, count2;

  logic       sp1 = 1'b0, sp2 = 1'b0;
  logic       sp1_prev = 1'b0, sp2_prev = 1'b0;
  logic       pot_load = 1'b0;
  logic [2:0] ld1 = 3'd0, ld2 = 3'd0;

  int         n_vec = 0;
  int         n_err = 0;
  logic [2:0] last_c1 = 3'd0, last_c2 = 3'd0;
  logic [1:0] last_id = 2'd0;

  class_decide #(.WINDOW_LEN(WL), .SETTLE_CYC(SC)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .potential1_s (pot1),
    .potential2_s (pot2),
    .en_s         (en_s),
    .busy         (busy),
    .class_valid  (class_valid),
    .class_ready  (class_ready),
    .class_id     (class_id),
    .count1       (count1),
    .count2       (count2)
  );

  always #5 clk = ~clk;

  // Output-neuron counter stage: counts spike rising edges only while enabled.
  always @(posedge clk) begin
    sp1_prev <= sp1;
    sp2_prev <= sp2;
    if (pot_load) begin
      pot1 <= ld1;
      pot2 <= ld2;
    end else begin
      if (en_s && sp1 && !sp1_prev) pot1 <= pot1 + 3'd1;
      if (en_s && sp2 && !sp2_prev) pot2 <= pot2 + 3'd1;
    end
  end

  // Bit k of a pattern is the spike level in cycle k after the start cycle.
  function automatic logic [2:0] ref_count(input logic [31:0] s);
    int n = 0;
    for (int k = 1; k <= WL; k++)
      if (s[k] && !s[k-1]) n++;
    return 3'(n);
  endfunction

  function automatic logic [1:0] exp_class(input logic [2:0] c1, input logic [2:0] c2);
    if (c1 == 3'd0 && c2 == 3'd0) return CLS_NONE;
    if (c1 == c2)                 return CLS_TIE;
    return (c1 > c2) ? CLS_N1 : CLS_N2;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_result(input string tag, input logic [2:0] c1, input logic [2:0] c2,
                            input logic [1:0] id);
    chk({tag, "_count1"}, 8'(count1), 8'(c1));
    chk({tag, "_count2"}, 8'(count2), 8'(c2));
    chk({tag, "_class_id"}, 8'(class_id), 8'(id));
  endtask

  // Preloads the neuron counters, then raises start for one cycle (cycle 0).
  task automatic begin_run(input logic [2:0] b1, input logic [2:0] b2, input logic s1_0,
                           input logic s2_0);
    @(negedge clk);
    pot_load = 1'b1; ld1 = b1; ld2 = b2; sp1 = 1'b0; sp2 = 1'b0;
    @(negedge clk);
    pot_load = 1'b0;
    chk("idle_busy", 8'(busy), 8'd0);
    start = 1'b1; sp1 = s1_0; sp2 = s2_0;
  endtask

  task automatic run_class(input string tag, input logic [2:0] b1, input logic [2:0] b2,
                           input logic [31:0] s1, input logic [31:0] s2,
                           input int rdy_dly, input bit poke_start);
    logic [2:0] e1, e2;
    logic [1:0] eid;
    e1  = ref_count(s1);
    e2  = ref_count(s2);
    eid = exp_class(e1, e2);
    begin_run(b1, b2, s1[0], s2[0]);
    for (int k = 1; k <= WL + SC + 1; k++) begin
      @(negedge clk);
      start = 1'b0; sp1 = s1[k]; sp2 = s2[k];
      chk({tag, "_en_s"}, 8'(en_s), 8'(k <= WL));
      chk({tag, "_valid_early"}, 8'(class_valid), 8'd0);
    end
    @(negedge clk);
    sp1 = 1'b0; sp2 = 1'b0;
    chk({tag, "_valid"}, 8'(class_valid), 8'd1);
    chk_result(tag, e1, e2, eid);
    for (int i = 0; i < rdy_dly; i++) begin
      start = poke_start;
      @(negedge clk);
      chk({tag, "_hold_valid"}, 8'(class_valid), 8'd1);
      chk_result({tag, "_hold"}, e1, e2, eid);
    end
    class_ready = 1'b1; start = poke_start;
    @(negedge clk);
    class_ready = 1'b0; start = 1'b0;
    chk({tag, "_done_valid"}, 8'(class_valid), 8'd0);
    chk({tag, "_done_busy"}, 8'(busy), 8'd0);
    last_c1 = e1; last_c2 = e2; last_id = eid;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_en_s"}, 8'(en_s), 8'd0);
    chk({tag, "_busy"}, 8'(busy), 8'd0);
    chk({tag, "_valid"}, 8'(class_valid), 8'd0);
    chk_result(tag, 3'd0, 3'd0, CLS_NONE);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    rst_n = 1'b1;

    run_class("n1_wins", 3'd3, 3'd5, 32'hAAAA_AAAA, 32'h0, 1, 1'b0);
    run_class("tie_wrap", 3'd6, 3'd6, 32'h0000_0124, 32'h0000_0124, 0, 1'b0);
    run_class("no_spike", 3'd2, 3'd7, 32'h0000_8001, 32'h0001_0000, 2, 1'b0);
    run_class("late_edge", 3'd0, 3'd4, 32'h0, 32'h0000_4000, 0, 1'b0);
    run_class("hold_out", 3'd1, 3'd2, 32'h0000_0A4A, 32'h0000_1212, 10, 1'b1);

    for (int r = 0; r < 12; r++) begin
      run_class("rand", 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                $urandom, $urandom, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    // Abort beats a simultaneous start in IDLE.
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("abort_idle_busy", 8'(busy), 8'd0);

    // Abort during WINDOW cycle 5.
    begin_run(3'd1, 3'd1, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0; sp1 = 1'b1;
    repeat (4) @(negedge clk);
    chk("abort_pre_en_s", 8'(en_s), 8'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0; sp1 = 1'b0;
    chk("abort_en_s", 8'(en_s), 8'd0);
    chk("abort_busy", 8'(busy), 8'd0);
    chk("abort_valid", 8'(class_valid), 8'd0);
    chk_result("abort_keep", last_c1, last_c2, last_id);
    for (int i = 0; i < WL + SC + 3; i++) begin
      @(negedge clk);
      chk("abort_no_valid", 8'(class_valid), 8'd0);
    end

    // Reset mid-WINDOW drops en_s without waiting for a clock edge.
    begin_run(3'd0, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("rstwin_pre_en_s", 8'(en_s), 8'd1);
    #2 rst_n = 1'b0;
    #1 chk("rstwin_en_s", 8'(en_s), 8'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset during SETTLE of a later run.
    begin_run(3'd2, 3'd3, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0; sp2 = 1'b1;
    repeat (WL) @(negedge clk);
    sp2 = 1'b0;
    chk("rstset_busy_pre", 8'(busy), 8'd1);
    #2 rst_n = 1'b0;
    #1 check_reset_state("rstset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < WL + SC + 3; i++) begin
      @(negedge clk);
      chk("rstset_no_valid", 8'(class_valid), 8'd0);
    end

    run_class("post_reset", 3'd7, 3'd0, 32'h0000_0006, 32'h0000_2492, 1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
